// File: rtl/dpram_burst_reader.sv
// Burst read master for port B of a dual-port RAM.
// A request (start address, beats-1) is turned into one RAM read per cycle
// with address wrap-around. A shift register tracks the RAM read latency,
// and returned words are buffered in a small FIFO that feeds a valid/ready
// stream. Reads are only issued when the FIFO is guaranteed to have room
// for every word already in flight, so backpressure never drops data.
module dpram_burst_reader #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LANTENCY = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [ADDR_WIDTH-1:0] i_req_len,
  output logic                  o_enb,
  output logic                  o_web,
  output logic [ADDR_WIDTH-1:0] o_addrb,
  output logic [DATA_WIDTH-1:0] o_dinb,
  input  logic [DATA_WIDTH-1:0] i_doutb,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_last,
  output logic                  o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] remain_reg;

  logic [READ_LANTENCY-1:0] pipe_valid_reg;
  logic [READ_LANTENCY-1:0] pipe_last_reg;
  logic [CNT_W-1:0]         inflight_reg;

  logic [DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    fifo_count_reg;

  logic                credit_ok;
  logic                issue;
  logic                issue_last;
  logic                push;
  logic                pop;
  logic [DATA_WIDTH:0] fifo_head;

  // Conservative credit: a pop in the same cycle is not counted as free space.
  assign credit_ok  = ({1'b0, inflight_reg} + {1'b0, fifo_count_reg}) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = (state_reg == ST_READ) && credit_ok;
  assign issue_last = issue && (remain_reg == '0);
  assign push       = pipe_valid_reg[READ_LANTENCY-1];
  assign pop        = o_data_valid && i_data_ready;
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  assign o_req_ready  = (state_reg == ST_IDLE);
  assign o_busy       = (state_reg != ST_IDLE);
  assign o_enb        = issue;
  assign o_web        = 1'b0;
  assign o_dinb       = '0;
  assign o_addrb      = issue ? addr_reg : '0;
  assign o_data_valid = (fifo_count_reg != '0);
  // Head is masked while empty so a stale entry never shows on the outputs.
  assign o_data       = o_data_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign o_data_last  = o_data_valid ? fifo_head[DATA_WIDTH] : 1'b0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Burst sequencing: accept in IDLE, issue in READ, wait for last pop in DRAIN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_req_valid) begin
            addr_reg   <= i_req_addr;
            remain_reg <= i_req_len;
            state_reg  <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_reg   <= addr_reg + ADDR_WIDTH'(1);
            remain_reg <= remain_reg - ADDR_WIDTH'(1);
            if (remain_reg == '0) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && o_data_last) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Latency shift register carrying {valid, last} alongside each RAM read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pipe_valid_reg <= '0;
      pipe_last_reg  <= '0;
    end else begin
      pipe_valid_reg[0] <= issue;
      pipe_last_reg[0]  <= issue_last;
      for (int i = 1; i < READ_LANTENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_last_reg[i]  <= pipe_last_reg[i-1];
      end
    end
  end

  // Reads issued whose data has not yet been captured into the FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_reg <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // FIFO storage: data plus last tag, written when a read leaves the pipeline.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {pipe_last_reg[READ_LANTENCY-1], i_doutb};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench for dpram_burst_reader with a behavioural port-B RAM.
module tb_dpram_burst_reader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LAT = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic          enb;
  logic          web;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic [DW-1:0] ram_dout = '0;
  logic          data_valid;
  logic          data_ready = 1'b1;
  logic [DW-1:0] data;
  logic          data_last;
  logic          busy;

  logic [DW-1:0] mem [16];

  int tests = 0;
  int fails = 0;
  int pop_count = 0;
  int outst = 0;

  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_beat_q [$];

  dpram_burst_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LANTENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_len(req_len),
    .o_enb(enb), .o_web(web), .o_addrb(addrb), .o_dinb(dinb),
    .i_doutb(ram_dout),
    .o_data_valid(data_valid), .i_data_ready(data_ready),
    .o_data(data), .o_data_last(data_last), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Port-B RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (enb && !web) ram_dout <= mem[addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enb"}, enb, 0);
    chk({tag, "_web"}, web, 0);
    chk({tag, "_addrb"}, addrb, 0);
    chk({tag, "_dinb"}, dinb, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_last"}, data_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push expectations, then present the request for one accept edge.
  task automatic do_req(input logic [AW-1:0] a, input logic [AW-1:0] len);
    logic [AW-1:0] ad;
    for (int k = 0; k <= int'(len); k++) begin
      ad = a + AW'(k);
      exp_addr_q.push_back(ad);
      exp_beat_q.push_back({(k == int'(len)), mem[ad]});
    end
    chk("req_ready_before_req", req_ready, 1);
    req_addr = a;
    req_len = len;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    $display("[TB] request addr=%0d len=%0d", a, len);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(req_ready && exp_beat_q.size() == 0) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_done_in_time"}, (n < 200), 1);
    chk({name, "_queue_empty"}, exp_beat_q.size(), 0);
  endtask

  // Monitor: checks every issued address and every popped beat against the queues.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] ea;
    logic [DW:0]   eb;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_addr_q.delete();
        exp_beat_q.delete();
        outst = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", data_valid, 1);
          chk("stall_data_held", data, prev_data);
          chk("stall_last_held", data_last, prev_last);
        end
        if (enb) begin
          chk("credit_room", (outst < DEPTH), 1);
          if (exp_addr_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            ea = exp_addr_q.pop_front();
            chk("issue_addr", addrb, ea);
          end
          outst++;
        end
        if (data_valid && data_ready) begin
          if (exp_beat_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            eb = exp_beat_q.pop_front();
            chk("beat_data", data, eb[DW-1:0]);
            chk("beat_last", data_last, eb[DW]);
            $display("[TB] beat data=%02h last=%0b", data, data_last);
          end
          outst--;
          pop_count++;
        end
        prev_stall = data_valid && !data_ready;
        prev_data = data;
        prev_last = data_last;
      end
    end
  end

  initial begin
    int n;
    int base;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem[3] = 8'hA5;

    // Reset at start-up.
    #1 rst = 1'b1;
    #1 chk_reset_outputs("por");
    step();
    step();
    rst = 1'b0;
    step();

    // Single beat: addr 3, len 0.
    do_req(4'd3, 4'd0);
    chk("single_c1_enb", enb, 1);
    chk("single_c1_addrb", addrb, 3);
    chk("single_c1_busy", busy, 1);
    step();
    chk("single_c2_valid", data_valid, 0);
    step();
    chk("single_c3_valid", data_valid, 1);
    chk("single_c3_data", data, 8'hA5);
    chk("single_c3_last", data_last, 1);
    step();
    chk("single_c4_idle", req_ready, 1);
    wait_idle("single");

    // Wrap-around: 14,15,0,1 giving 1E,1F,10,11.
    do_req(4'd14, 4'd3);
    wait_idle("wrap");

    // Full throughput: 16 beats on consecutive cycles.
    do_req(4'd5, 4'd15);
    n = 0;
    while (!data_valid && n < 20) begin
      step();
      n++;
    end
    chk("thru_first_valid_in_time", (n < 20), 1);
    for (int i = 0; i < 16; i++) begin
      chk("thru_valid_consecutive", data_valid, 1);
      step();
    end
    chk("thru_req_ready_after_last", req_ready, 1);
    wait_idle("thru");

    // Backpressure: ready low for cycles 3..9 of an 8-beat burst.
    do_req(4'd2, 4'd7);
    for (int c = 1; c <= 12; c++) begin
      data_ready = !(c >= 3 && c <= 9);
      step();
    end
    data_ready = 1'b1;
    wait_idle("bp");

    // Abort: reset after the 2nd beat; a request during READ is ignored.
    base = pop_count;
    do_req(4'd0, 4'd7);
    req_addr = 4'd9;
    req_len = 4'd0;
    req_valid = 1'b1;
    chk("ignore_req_ready_low", req_ready, 0);
    step();
    chk("ignore_req_ready_low2", req_ready, 0);
    req_valid = 1'b0;
    n = 0;
    while (pop_count < base + 2 && n < 50) begin
      step();
      n++;
    end
    chk("abort_two_beats_in_time", (n < 50), 1);
    @(posedge clk);
    #2 req_valid = 1'b1;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    step();
    step();
    chk_reset_outputs("abort_held");
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_reset_outputs("after_abort");
    base = pop_count;
    do_req(4'd0, 4'd1);
    wait_idle("fresh");
    for (int i = 0; i < 5; i++) step();
    chk("fresh_beat_count", pop_count - base, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
